// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad emulator and the scanner
// that talks to it. Holds the emulator state encoding, the key-to-(row,col)
// lookup and the constants of the bounce LFSR.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HELD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback is the XOR of bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Physical layout:  row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: E 0 F D
  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t p;
    case (key)
      4'h1: p = '{row: 2'd0, col: 2'd0};
      4'h2: p = '{row: 2'd0, col: 2'd1};
      4'h3: p = '{row: 2'd0, col: 2'd2};
      4'hA: p = '{row: 2'd0, col: 2'd3};
      4'h4: p = '{row: 2'd1, col: 2'd0};
      4'h5: p = '{row: 2'd1, col: 2'd1};
      4'h6: p = '{row: 2'd1, col: 2'd2};
      4'hB: p = '{row: 2'd1, col: 2'd3};
      4'h7: p = '{row: 2'd2, col: 2'd0};
      4'h8: p = '{row: 2'd2, col: 2'd1};
      4'h9: p = '{row: 2'd2, col: 2'd2};
      4'hC: p = '{row: 2'd2, col: 2'd3};
      4'hE: p = '{row: 2'd3, col: 2'd0};
      4'h0: p = '{row: 2'd3, col: 2'd1};
      4'hF: p = '{row: 2'd3, col: 2'd2};
      default: p = '{row: 2'd3, col: 2'd3}; // 4'hD
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR used as the contact-bounce source.
// Shifts left, new bit enters at bit 0. Seeded non-zero, so never all-zero.
module lfsr8
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next value: shift in the XOR of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: far end of a 4x4 row-strobe / column-sense keypad.
// Accepts a key over valid/ready and plays it as a physical press.
// Optional feature macro: KEYPAD_EMU_BOUNCE_EN (contact bounce on press and
// release using lfsr8). Without it a press is HELD then GAP only.
//
// Handshake: a transfer happens on a rising edge where key_valid && key_ready;
// key_ready is high only in IDLE, key_code is sampled only on that edge, and
// key_valid at any other time is ignored (nothing is queued).
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GAP_CYCLES    = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic       pressed,
  output state_t     state_dbg_o
);

  localparam int unsigned MAX_HB = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  key_q, key_d;
  logic        pressed_q, pressed_d;
  logic        bounce_bit;
  key_pos_t    pos;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [6:0] lfsr_unused;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .out   ({lfsr_unused, bounce_bit})
  );
`else
  assign bounce_bit = 1'b0;
`endif

  // Next-state, counter reload, key latch and contact value of the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          key_d = key_code;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = S_BOUNCE_IN;
          cnt_d   = CW'(BOUNCE_CYCLES);
`else
          state_d = S_HELD;
          cnt_d   = CW'(HOLD_CYCLES);
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_BOUNCE_IN: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_HELD;
          cnt_d   = CW'(HOLD_CYCLES);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_BOUNCE_OUT: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_CYCLES);
        end else cnt_d = cnt_q - CW'(1);
      end
`endif
      S_HELD: begin
        if (cnt_q == CW'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = S_BOUNCE_OUT;
          cnt_d   = CW'(BOUNCE_CYCLES);
`else
          state_d = S_GAP;
          cnt_d   = CW'(GAP_CYCLES);
`endif
        end else cnt_d = cnt_q - CW'(1);
      end
      S_GAP: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Contact is registered against the state being entered, so the first
    // contact value of a state is visible in that state's first cycle.
    case (state_d)
      S_HELD:                    pressed_d = 1'b1;
      S_BOUNCE_IN, S_BOUNCE_OUT: pressed_d = bounce_bit;
      default:                   pressed_d = 1'b0;
    endcase
  end

  // State, counter, latched key and contact registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_q     <= 4'h0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
    end
  end

  assign pos = key_to_pos(key_q);

  // Zero-latency column sense: pull the key's column low while its row is strobed.
  always_comb begin
    columns = 4'b1111;
    if (pressed_q && rows[2'd3 - pos.row]) columns[2'd3 - pos.col] = 1'b0;
  end

  assign pressed     = pressed_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed self-checking bench for keypad_emulator.
// Works with or without KEYPAD_EMU_BOUNCE_EN; expected timing adapts to it.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD   = 4;
  localparam int BOUNCE = 8;
  localparam int GAP    = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BIN = BOUNCE;
`else
  localparam int BIN = 0;
`endif
  localparam int BUSY = 2 * BIN + HOLD + GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [3:0] rows = 4'b0000;
  logic [3:0] columns;
  logic       pressed;
  state_t     state_dbg;

  int checks = 0;
  int failures = 0;

  // Physical key layout, written out independently of the design.
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_emulator #(.HOLD_CYCLES(HOLD), .BOUNCE_CYCLES(BOUNCE), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .rows        (rows),
    .columns     (columns),
    .pressed     (pressed),
    .state_dbg_o (state_dbg)
  );

  // Clock/reset block.
  always #5 clk = ~clk;

  // Reference bounce source: x^8+x^6+x^5+x^4+1 from seed A5, one step per edge.
  // bounce_bit is the LFSR bit 0 that was current just before the last edge.
  logic [7:0] lfsr_m = 8'hA5;
  logic       bounce_bit = 1'b0;
  always @(posedge clk) begin
    bounce_bit = lfsr_m[0];
    if (reset) lfsr_m = 8'hA5;
    else       lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Driver tasks. All driving and sampling happens at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic exp_contact(input int k);
    if (k <= BIN)                 return bounce_bit;
    else if (k <= BIN + HOLD)     return 1'b1;
    else if (k <= 2 * BIN + HOLD) return bounce_bit;
    else                          return 1'b0;
  endfunction

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!key_ready && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready: key_ready=%b after %0d cycles, required 1", key_ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || pressed !== 1'b0 || columns !== 4'b1111 || state_dbg !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: ready=%b pressed=%b columns=%b state=%0d, required 1 0 1111 0",
               key_ready, pressed, columns, state_dbg);
    end
    for (int r = 0; r < 4; r++) begin
      rows = 4'b1000 >> r;
      step();
      checks++;
      if (columns !== 4'b1111 || key_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_rows: rows=%b columns=%b ready=%b, required 1111 1", rows, columns, key_ready);
      end
    end
    rows = 4'b0000;
  endtask

  // One full press: contact profile, busy window, and a column check in HELD.
  task automatic test_press(input logic [3:0] key, input logic [3:0] row_hit,
                            input logic [3:0] col_exp, input logic [3:0] row_miss);
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL press_start_ready: key=%h ready=%b, required 1", key, key_ready);
    end
    key_code  = key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key_code  = 4'hF - key;
    for (int k = 1; k <= BUSY; k++) begin
      checks++;
      if (key_ready !== 1'b0 || pressed !== exp_contact(k)) begin
        failures++;
        $display("FAIL press_profile: key=%h cycle=%0d ready=%b pressed=%b, required 0 %b",
                 key, k, key_ready, pressed, exp_contact(k));
      end
      if (k == BIN + 1) begin
        rows = row_hit;
        #1;
        checks++;
        if (columns !== col_exp) begin
          failures++;
          $display("FAIL press_col_hit: key=%h rows=%b columns=%b, required %b", key, rows, columns, col_exp);
        end
        rows = row_miss;
        #1;
        checks++;
        if (columns !== 4'b1111) begin
          failures++;
          $display("FAIL press_col_miss: key=%h rows=%b columns=%b, required 1111", key, rows, columns);
        end
        rows = 4'b0000;
      end
      if (k == BUSY) begin
        rows = row_hit;
        #1;
        checks++;
        if (columns !== 4'b1111) begin
          failures++;
          $display("FAIL press_gap_col: key=%h columns=%b, required 1111", key, columns);
        end
        rows = 4'b0000;
      end
      step();
    end
    checks++;
    if (key_ready !== 1'b1 || pressed !== 1'b0) begin
      failures++;
      $display("FAIL press_end: key=%h ready=%b pressed=%b, required 1 0", key, key_ready, pressed);
    end
  endtask

  task automatic test_ignored();
    key_code  = 4'h1;
    key_valid = 1'b1;
    step();
    key_code = 4'h3;
    for (int k = 1; k <= BUSY; k++) begin
      if (k == 3) key_valid = 1'b0;
      if (k == BIN + 2) begin
        rows = 4'b1000;
        #1;
        checks++;
        if (columns !== 4'b0111) begin
          failures++;
          $display("FAIL ignored_key_col: columns=%b, required 0111", columns);
        end
        rows = 4'b0000;
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (key_ready !== 1'b1 || pressed !== 1'b0) begin
        failures++;
        $display("FAIL ignored_no_queue: ready=%b pressed=%b, required 1 0", key_ready, pressed);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    key_code  = 4'h5;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int k = 1; k < BIN + 2; k++) step();
    checks++;
    if (pressed !== 1'b1) begin
      failures++;
      $display("FAIL mid_held_pressed: pressed=%b, required 1", pressed);
    end
    reset = 1'b1;
    step();
    rows = 4'b0100;
    #1;
    checks++;
    if (pressed !== 1'b0 || columns !== 4'b1111 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: pressed=%b columns=%b ready=%b, required 0 1111 1", pressed, columns, key_ready);
    end
    rows  = 4'b0000;
    reset = 1'b0;
    step();
    test_press(4'h5, 4'b0100, 4'b1011, 4'b1000);
  endtask

  task automatic test_back_to_back();
    key_code  = 4'h6;
    key_valid = 1'b1;
    step();
    for (int k = 1; k <= BUSY + 1; k++) begin
      if (k == BIN + 1) begin
        rows = 4'b0100;
        #1;
        checks++;
        if (columns !== 4'b1101) begin
          failures++;
          $display("FAIL b2b_first_col: columns=%b, required 1101", columns);
        end
        rows = 4'b0000;
      end
      if (k == BUSY) begin
        checks++;
        if (key_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_busy_end: ready=%b, required 0", key_ready);
        end
      end
      if (k == BUSY + 1) begin
        checks++;
        if (key_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_back: ready=%b, required 1", key_ready);
        end
        key_code = 4'h7;
      end
      step();
    end
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: ready=%b, required 0", key_ready);
    end
    key_valid = 1'b0;
    for (int k = 1; k < BIN + 1; k++) step();
    rows = 4'b0010;
    #1;
    checks++;
    if (columns !== 4'b0111) begin
      failures++;
      $display("FAIL b2b_second_col: columns=%b, required 0111", columns);
    end
    rows = 4'b0000;
    wait_ready(BUSY + 4);
  endtask

  // Behavioural scanner: strobe every row during HELD and decode the columns.
  task automatic test_closed_loop();
    for (int key = 0; key < 16; key++) begin
      int hits = 0;
      logic [3:0] decoded = 4'h0;
      key_code  = 4'(key);
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      for (int k = 1; k < BIN + 1; k++) step();
      for (int r = 0; r < 4; r++) begin
        rows = 4'b1000 >> r;
        #1;
        for (int c = 0; c < 4; c++) begin
          if (columns[3 - c] == 1'b0) begin
            hits++;
            decoded = kmap[r][c];
          end
        end
      end
      rows = 4'b0000;
      checks++;
      if (hits != 1 || decoded !== 4'(key)) begin
        failures++;
        $display("FAIL scan_decode: issued=%h decoded=%h hits=%0d, required %h once", key, decoded, hits, key);
      end
      wait_ready(BUSY + 4);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press(4'h5, 4'b0100, 4'b1011, 4'b1000);
    test_press(4'hD, 4'b0001, 4'b1110, 4'b1000);
    test_press(4'h1, 4'b1000, 4'b0111, 4'b0100);
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_closed_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
